// File: rtl/mode_cycler_pkg.sv
// -----------------------------------------------------------------------------
// mode_cycler_pkg
//   Shared constants for the mode cycler slice.
//   - wave_mode_e    : names of the seven waveform modes, in cycling order.
//   - DEFAULT_N_MODES: number of modes selectable by default.
//   - DEFAULT_MODE_W : mode bus width that fits DEFAULT_N_MODES.
// -----------------------------------------------------------------------------
package mode_cycler_pkg;

  localparam int DEFAULT_N_MODES = 7;
  localparam int DEFAULT_MODE_W  = 3;

  typedef enum logic [2:0] {
    SAWTOOTH         = 3'd0,
    SQUARE           = 3'd1,
    REVERSE_SAWTOOTH = 3'd2,
    TRIANGLE         = 3'd3,
    SINE             = 3'd4,
    TRUMPET          = 3'd5,
    VIOLIN           = 3'd6
  } wave_mode_e;

endpackage

// File: rtl/mode_cycler_if.sv
// -----------------------------------------------------------------------------
// mode_cycler_if
//   Groups the user-facing signals of mode_cycler.
//   Inputs to the cycler : en, next_pb, prev_pb (raw buttons, active-high)
//   Outputs of the cycler: wave_mode (gated by en), mode_state (raw register),
//                          mode_changed (one-cycle pulse on a mode change)
//   Modports: master = the side driving buttons/enable, slave = mode_cycler.
// -----------------------------------------------------------------------------
interface mode_cycler_if
  import mode_cycler_pkg::*;
#(
  parameter int MODE_W = DEFAULT_MODE_W
) ();

  logic              en;
  logic              next_pb;
  logic              prev_pb;
  logic [MODE_W-1:0] wave_mode;
  logic [MODE_W-1:0] mode_state;
  logic              mode_changed;

  modport master (
    output en,
    output next_pb,
    output prev_pb,
    input  wave_mode,
    input  mode_state,
    input  mode_changed
  );

  modport slave (
    input  en,
    input  next_pb,
    input  prev_pb,
    output wave_mode,
    output mode_state,
    output mode_changed
  );

endinterface

// File: rtl/mode_cycler_pb_conditioner.sv
// -----------------------------------------------------------------------------
// pb_conditioner
//   Turns one raw asynchronous pushbutton into single-cycle step requests.
//   Chain: 2-flop synchronizer -> debouncer -> rising-edge detect -> auto-repeat.
//   Ports:
//     clk  : system clock
//     nrst : asynchronous active-low reset (clears every flop)
//     pb   : raw button level, active-high
//     step : registered one-cycle step request
//   Timing: the first edge that samples pb high is edge 1; the accepted level
//   rises on edge DEBOUNCE+2 and step is high for the cycle after that edge,
//   so a consumer sampling step moves on edge DEBOUNCE+3.
// -----------------------------------------------------------------------------
module pb_conditioner #(
  parameter int DEBOUNCE      = 50000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 2000000
) (
  input  logic clk,
  input  logic nrst,
  input  logic pb,
  output logic step
);

  // Debounce counter counts 0..DEBOUNCE-1.
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  // Repeat counter is shared by the initial delay and the repeat period.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = (REPEAT_DELAY > 0) ? RPT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;   // 0: waiting REPEAT_DELAY, 1: periodic
  logic             step_q, step_d;

  always_comb begin
    sync_d      = {sync_q[0], pb};
    level_d     = level_q;
    db_cnt_d    = db_cnt_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    step_d      = 1'b0;

    // Debounce: any agreeing cycle clears the run; DEBOUNCE differing cycles flip.
    if (sync_q[1] == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    // Step on the accepted rising edge, then auto-repeat while the level
    // stays high (level_q and level_d both high, so a falling level never
    // produces a final repeat).
    if (level_d && !level_q) begin
      step_d      = 1'b1;
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end else if (level_d && level_q && (REPEAT_DELAY > 0)) begin
      if (!rpt_armed_q) begin
        if (rpt_cnt_q == DELAY_LAST) begin
          step_d      = 1'b1;
          rpt_cnt_d   = '0;
          rpt_armed_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end else begin
        if (rpt_cnt_q == PERIOD_LAST) begin
          step_d    = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level_d;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
      step_q      <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/mode_cycler.sv
// -----------------------------------------------------------------------------
// mode_cycler
//   Cycles a mode register up/down with two debounced pushbuttons.
//   Ports:
//     MHz10 : system clock (rising edge)
//     nrst  : asynchronous active-low reset
//     bus   : mode_cycler_if.slave
//             en, next_pb, prev_pb in; wave_mode, mode_state, mode_changed out
//   Button conditioning lives in pb_conditioner (one per button); this module
//   only holds the mode register and the step arithmetic. Steps are dropped
//   while en=0; simultaneous next/prev steps cancel; ends wrap or saturate
//   according to WRAP. An out-of-range register value is forced to 0.
// -----------------------------------------------------------------------------
module mode_cycler
  import mode_cycler_pkg::*;
#(
  parameter int N_MODES       = DEFAULT_N_MODES,
  parameter int MODE_W        = DEFAULT_MODE_W,
  parameter int DEBOUNCE      = 50000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 2000000,
  parameter int WRAP          = 1
) (
  input  logic          MHz10,
  input  logic          nrst,
  mode_cycler_if.slave  bus
);

  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(N_MODES - 1);

  // Index 0 = next button, index 1 = prev button.
  logic [1:0] pb_raw;
  logic [1:0] pb_step;

  assign pb_raw = {bus.prev_pb, bus.next_pb};

  for (genvar gi = 0; gi < 2; gi++) begin : g_pb
    pb_conditioner #(
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_pb (
      .clk  (MHz10),
      .nrst (nrst),
      .pb   (pb_raw[gi]),
      .step (pb_step[gi])
    );
  end

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              changed_q, changed_d;

  always_comb begin
    mode_d = mode_q;
    if (int'(mode_q) >= N_MODES) begin
      mode_d = '0;
    end else if (bus.en && (pb_step[0] != pb_step[1])) begin
      if (pb_step[0]) begin
        if (mode_q == LAST_MODE) mode_d = (WRAP != 0) ? '0 : mode_q;
        else                     mode_d = mode_q + 1'b1;
      end else begin
        if (mode_q == '0) mode_d = (WRAP != 0) ? LAST_MODE : mode_q;
        else              mode_d = mode_q - 1'b1;
      end
    end
    // A saturated step leaves mode_d == mode_q, so no pulse.
    changed_d = (mode_d != mode_q);
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      mode_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      changed_q <= changed_d;
    end
  end

  assign bus.mode_state   = mode_q;
  assign bus.mode_changed = changed_q;
  assign bus.wave_mode    = bus.en ? mode_q : '0;

endmodule

// File: tb/tb_mode_cycler.sv
// -----------------------------------------------------------------------------
// tb_mode_cycler
//   Two instances: dut_a (WRAP=1, auto-repeat 20/8) and dut_b (WRAP=0,
//   auto-repeat off), both DEBOUNCE=4, N_MODES=7. A behavioural model built
//   from the button/mode rules predicts every output each cycle; a table of
//   directed presses checks final mode, pulse count and change edges; short
//   hand-written sequences cover glitches and reset mid-press; then random
//   presses run against the model.
// -----------------------------------------------------------------------------
module tb_mode_cycler;

  localparam int N  = 7;
  localparam int DB = 4;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  mode_cycler_if #(.MODE_W(3)) ifa ();
  mode_cycler_if #(.MODE_W(3)) ifb ();

  mode_cycler #(.N_MODES(7), .MODE_W(3), .DEBOUNCE(4), .REPEAT_DELAY(20),
                .REPEAT_PERIOD(8), .WRAP(1))
    dut_a (.MHz10(clk), .nrst(nrst), .bus(ifa));

  mode_cycler #(.N_MODES(7), .MODE_W(3), .DEBOUNCE(4), .REPEAT_DELAY(0),
                .REPEAT_PERIOD(8), .WRAP(0))
    dut_b (.MHz10(clk), .nrst(nrst), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  // ---------------- input / output access ----------------
  function automatic int rd_of(input int d);   return (d == 0) ? 20 : 0; endfunction
  function automatic bit wrap_of(input int d); return (d == 0);          endfunction

  function automatic bit raw_in(input int d, input int b);
    if (d == 0) return (b == 0) ? ifa.next_pb : ifa.prev_pb;
    return (b == 0) ? ifb.next_pb : ifb.prev_pb;
  endfunction
  function automatic bit en_in(input int d);
    return (d == 0) ? ifa.en : ifb.en;
  endfunction
  function automatic int out_mode(input int d);
    return (d == 0) ? int'(ifa.mode_state) : int'(ifb.mode_state);
  endfunction
  function automatic int out_wave(input int d);
    return (d == 0) ? int'(ifa.wave_mode) : int'(ifb.wave_mode);
  endfunction
  function automatic int out_chg(input int d);
    return (d == 0) ? int'(ifa.mode_changed) : int'(ifb.mode_changed);
  endfunction

  task automatic set_in(input int d, input bit nx, input bit pv, input bit e);
    if (d == 0) begin ifa.next_pb = nx; ifa.prev_pb = pv; ifa.en = e; end
    else        begin ifb.next_pb = nx; ifb.prev_pb = pv; ifb.en = e; end
  endtask

  task automatic check(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d at %0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Per button: raw samples from the last two edges (synchronizer delay),
  // a window of the last DB synchronized samples, the accepted level and the
  // edge number at which it rose. A step is owed on the rise, at rise+delay,
  // and every period after that while the level stays high.
  bit m_raw1 [2][2];
  bit m_raw2 [2][2];
  bit m_win  [2][2][DB];
  bit m_acc  [2][2];
  int m_rise [2][2];
  bit m_step [2][2];
  int m_mode [2];
  bit m_chg  [2];
  int m_t = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0;
      m_chg[d]  = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_raw1[d][b] = 1'b0; m_raw2[d][b] = 1'b0; m_acc[d][b] = 1'b0;
        m_rise[d][b] = 0;    m_step[d][b] = 1'b0;
        for (int i = 0; i < DB; i++) m_win[d][b][i] = 1'b0;
      end
    end
  endtask

  task automatic model_tick();
    m_t++;
    for (int d = 0; d < 2; d++) begin
      int nm;
      nm = m_mode[d];
      if (en_in(d) && (m_step[d][0] != m_step[d][1])) begin
        if (m_step[d][0])
          nm = wrap_of(d) ? (m_mode[d] + 1) % N : ((m_mode[d] + 1 > N - 1) ? N - 1 : m_mode[d] + 1);
        else
          nm = wrap_of(d) ? (m_mode[d] + N - 1) % N : ((m_mode[d] < 1) ? 0 : m_mode[d] - 1);
      end
      m_chg[d]  = (nm != m_mode[d]);
      m_mode[d] = nm;
      for (int b = 0; b < 2; b++) begin
        bit all_diff, nacc, st;
        int k;
        for (int i = DB - 1; i > 0; i--) m_win[d][b][i] = m_win[d][b][i-1];
        m_win[d][b][0] = m_raw2[d][b];
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (m_win[d][b][i] == m_acc[d][b]) all_diff = 1'b0;
        nacc = all_diff ? !m_acc[d][b] : m_acc[d][b];
        st = 1'b0;
        if (nacc && !m_acc[d][b]) begin
          st = 1'b1;
          m_rise[d][b] = m_t;
        end else if (nacc && m_acc[d][b] && rd_of(d) > 0) begin
          k = m_t - m_rise[d][b];
          if (k == rd_of(d) || (k > rd_of(d) && (k - rd_of(d)) % RP == 0)) st = 1'b1;
        end
        m_acc[d][b]  = nacc;
        m_step[d][b] = st;
        m_raw2[d][b] = m_raw1[d][b];
        m_raw1[d][b] = raw_in(d, b);
      end
    end
  endtask

  // One clock: advance the model with the inputs sampled on the edge, then
  // compare all outputs of both DUTs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!nrst) model_reset();
    else       model_tick();
    for (int d = 0; d < 2; d++) begin
      check("mode_state",   d, out_mode(d), m_mode[d]);
      check("mode_changed", d, out_chg(d),  int'(m_chg[d]));
      check("wave_mode",    d, out_wave(d), en_in(d) ? m_mode[d] : 0);
    end
  endtask

  // ---------------- directed press table ----------------
  typedef struct {
    int dut;
    int nxt_len;
    int prv_len;
    int prv_ofs;
    bit en_val;
    int exp_mode;
    int exp_pulses;
    int exp_first;   // edge of first change within the window, 0 = none
    int exp_last;    // edge of last change within the window, 0 = none
  } vec_t;

  localparam int NV  = 12;
  localparam int WIN = 80;
  vec_t vecs [NV];

  initial begin
    int pulses, first_e, last_e, d;

    //           dut nxt prv ofs en mode pulses first last
    vecs[0]  = '{1, 30,  0, 0, 1'b1, 1, 1, 7,  7};   // clean press, no repeat
    vecs[1]  = '{1,  0, 10, 0, 1'b1, 0, 1, 7,  7};
    vecs[2]  = '{1,  0, 10, 0, 1'b1, 0, 0, 0,  0};   // prev at 0 saturates
    vecs[3]  = '{1, 10, 10, 2, 1'b1, 0, 2, 7,  9};   // staggered: both apply
    vecs[4]  = '{1, 10, 10, 0, 1'b1, 0, 0, 0,  0};   // same cycle: cancel
    vecs[5]  = '{0, 60,  0, 0, 1'b1, 6, 6, 7, 59};   // auto-repeat 7,27,35,..,59
    vecs[6]  = '{0, 10,  0, 0, 1'b1, 0, 1, 7,  7};   // wrap 6 -> 0
    vecs[7]  = '{0,  0, 10, 0, 1'b1, 6, 1, 7,  7};   // wrap 0 -> 6
    vecs[8]  = '{0,  3,  0, 0, 1'b1, 6, 0, 0,  0};   // one short of debounce
    vecs[9]  = '{0,  4,  0, 0, 1'b1, 0, 1, 7,  7};   // exactly debounce
    vecs[10] = '{0, 10,  0, 0, 1'b0, 0, 0, 0,  0};   // disabled: dropped
    vecs[11] = '{0,  0, 30, 0, 1'b1, 4, 3, 7, 35};   // prev repeat 0->6->5->4

    nrst = 1'b0;
    set_in(0, 1'b0, 1'b0, 1'b1);
    set_in(1, 1'b0, 1'b0, 1'b1);
    model_reset();
    #2;
    for (int d2 = 0; d2 < 2; d2++) begin
      check("reset_mode", d2, out_mode(d2), 0);
      check("reset_chg",  d2, out_chg(d2),  0);
    end
    for (int i = 0; i < 3; i++) tick();
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    for (int r = 0; r < NV; r++) begin
      d = vecs[r].dut;
      pulses = 0; first_e = 0; last_e = 0;
      for (int k = 0; k < WIN; k++) begin
        set_in(d, k < vecs[r].nxt_len,
               (k >= vecs[r].prv_ofs) && (k < vecs[r].prv_ofs + vecs[r].prv_len),
               vecs[r].en_val);
        set_in(1 - d, 1'b0, 1'b0, 1'b1);
        tick();
        if (out_chg(d) != 0) begin
          pulses++;
          if (first_e == 0) first_e = k + 1;
          last_e = k + 1;
        end
      end
      set_in(d, 1'b0, 1'b0, 1'b1);
      check($sformatf("row%0d_mode", r),   d, out_mode(d), vecs[r].exp_mode);
      check($sformatf("row%0d_pulses", r), d, pulses,      vecs[r].exp_pulses);
      check($sformatf("row%0d_first", r),  d, first_e,     vecs[r].exp_first);
      check($sformatf("row%0d_last", r),   d, last_e,      vecs[r].exp_last);
    end

    // Glitches of 1-3 cycles separated by single low cycles: never accepted.
    begin
      int gl [10] = '{1, 1, 2, 1, 3, 1, 2, 1, 1, 1};
      pulses = 0;
      for (int g = 0; g < 10; g++) begin
        for (int c = 0; c < gl[g]; c++) begin
          set_in(0, (g % 2) == 0, 1'b0, 1'b1);
          tick();
          if (out_chg(0) != 0) pulses++;
        end
      end
      set_in(0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
        tick();
        if (out_chg(0) != 0) pulses++;
      end
      check("glitch_mode",   0, out_mode(0), 4);
      check("glitch_pulses", 0, pulses,      0);
    end

    // Reset mid-press at mode 4; held button counts as a fresh press.
    check("pre_reset_mode", 0, out_mode(0), 4);
    set_in(0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    nrst = 1'b0;
    #1;
    check("async_reset_mode", 0, out_mode(0), 0);
    check("async_reset_wave", 0, out_wave(0), 0);
    check("async_reset_chg",  0, out_chg(0),  0);
    for (int i = 0; i < 2; i++) tick();
    nrst = 1'b1;
    first_e = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_chg(0) != 0 && first_e == 0) first_e = k + 1;
    end
    check("post_reset_edge", 0, first_e,     DB + 3);
    check("post_reset_mode", 0, out_mode(0), 1);
    set_in(0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick();

    // Random presses against the model.
    for (int it = 0; it < 60; it++) begin
      int nl [2], pl [2], po [2], enm [2];
      for (int d2 = 0; d2 < 2; d2++) begin
        nl[d2]  = $urandom_range(0, 35);
        pl[d2]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 35) : 0;
        po[d2]  = $urandom_range(0, 10);
        enm[d2] = $urandom_range(0, 3);
      end
      for (int k = 0; k < 50; k++) begin
        for (int d2 = 0; d2 < 2; d2++) begin
          set_in(d2, k < nl[d2], (k >= po[d2]) && (k < po[d2] + pl[d2]),
                 (enm[d2] != 0) ? 1'b1 : ($urandom_range(0, 2) != 0));
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
